fp8_to_fixed: RTL and testbench
===============================

FP8_TO_FIXED -- requirements
Module: fp8_to_fixed

Interface
REQ-001 SHALL have port clk, input, 1 bit: single rising-edge clock for all state.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-003 SHALL have port start, input, 1 bit: request to convert op; honoured only in IDLE.
REQ-004 SHALL have port op, input, 8 bits: FP8 operand, S=op[7], E=op[6:4] unsigned, F=op[3:0] unsigned magnitude.
REQ-005 SHALL have port busy, output, 1 bit: high while a conversion is in progress.
REQ-006 SHALL have port done, output, 1 bit: one-cycle pulse when res/zero/denorm are updated.
REQ-007 SHALL have port res, output, 12 bits: signed two's-complement fixed point Q7.4 (value x 16).
REQ-008 SHALL have port zero, output, 1 bit: result is zero.
REQ-009 SHALL have port denorm, output, 1 bit: operand had F!=0 and F[3]=0.

Function
REQ-010 SHALL interpret op as value = (-1)^S x (F/16) x 2^E, so that res = (-1)^S x F x 2^E.
REQ-011 SHALL have magnitude F x 2^E <= 1920, so res never overflows 12 bits; no saturation logic.
REQ-012 SHALL implement states IDLE, SHIFT, SIGN only.
REQ-013 In IDLE with start=1, SHALL on the edge capture S, set acc={8'b0,F}, set cnt=E, set busy=1 and go to SHIFT.
REQ-014 In IDLE with start=1, SHALL also latch the denorm condition internally on the same edge.
REQ-015 In SHIFT with cnt!=0, SHALL on each edge set acc=acc<<1 and cnt=cnt-1 (one bit per cycle; no barrel shifter).
REQ-016 In SHIFT with cnt==0, SHALL go to SIGN on the edge without modifying acc.
REQ-017 In SIGN, SHALL on the edge set res=(S ? -acc : acc) and zero=(acc==0).
REQ-018 In SIGN, SHALL on the same edge update denorm, pulse done=1, clear busy and return to IDLE.
REQ-019 SHALL map negative zero (S=1, F=0) to res=0x000 with zero=1; the sign is discarded.
REQ-020 SHALL convert a denormal operand exactly as given, with no pre-normalisation; only the flag is raised.
REQ-021 SHALL have latency: done high in the cycle E+2 edges after the capturing edge (2..9 cycles); busy high for exactly E+2 cycles.
REQ-022 SHALL ignore start while busy=1; op changes during busy SHALL NOT affect the result.
REQ-023 SHALL hold res, zero and denorm stable from the done edge until the next done edge.
REQ-024 SHALL hold done at 0 in all cycles other than the SIGN-exit cycle.
REQ-025 SHALL accept start=1 in the cycle done=1; that cycle is IDLE, giving back-to-back conversions with no gap.

Reset
REQ-026 On rst=1 at a clock edge, SHALL set state=IDLE, busy=0, done=0, res=0x000, zero=0, denorm=0, acc=0, cnt=0.
REQ-027 SHALL give rst priority over start and over any in-flight state; a conversion aborted by reset produces no done pulse.
REQ-028 SHALL hold all outputs at their reset values from the edge after rst deasserts until the first completed conversion.

Verification
REQ-029 SHALL cover: op=0x3C, start pulse -> done 5 cycles later, res=0x060 (+6.0), zero=0, denorm=0.
REQ-030 SHALL cover: op=0xFF -> done after 9 cycles, res=0x880 (-1920/16=-120.0), busy high 9 cycles.
REQ-031 SHALL cover: op=0x80 (negative zero) -> done after 2 cycles, res=0x000, zero=1, denorm=0.
REQ-032 SHALL cover: op=0x05 -> done after 2 cycles, res=0x005 (+0.3125), denorm=1.
REQ-033 SHALL cover: op=0x7F start, second start with op=0x11 during busy -> single done, res=0x780; then start in the done cycle with 0x11 -> res=0x002 three cycles later.
REQ-034 SHALL cover: rst=1 asserted mid-SHIFT for op=0x70 -> next cycle busy=0, res=0x000, no done pulse; a subsequent op=0x48 converts to res=0x080.

Source files
------------

// File: rtl/fp8_to_fixed.sv
// rtl/fp8_to_fixed.sv - sequential FP8 (S.E3.F4) to signed Q7.4 fixed-point converter
module fp8_to_fixed (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  op,
  output logic        busy,
  output logic        done,
  output logic [11:0] res,
  output logic        zero,
  output logic        denorm
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    SIGN  = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [11:0] acc, acc_n;
  logic [2:0]  cnt, cnt_n;
  logic        sign, sign_n;
  logic        dn_lat, dn_lat_n;
  logic        busy_n, done_n, zero_n, denorm_n;
  logic [11:0] res_n;

  // Next-state and datapath: capture in IDLE, shift one bit per cycle, apply sign on exit
  always_comb begin
    state_n  = state;
    acc_n    = acc;
    cnt_n    = cnt;
    sign_n   = sign;
    dn_lat_n = dn_lat;
    busy_n   = busy;
    done_n   = 1'b0;
    res_n    = res;
    zero_n   = zero;
    denorm_n = denorm;
    case (state)
      IDLE: begin
        if (start) begin
          sign_n   = op[7];
          acc_n    = {8'b0, op[3:0]};
          cnt_n    = op[6:4];
          dn_lat_n = (op[3:0] != 4'd0) && !op[3];
          busy_n   = 1'b1;
          state_n  = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt != 3'd0) begin
          acc_n = {acc[10:0], 1'b0};
          cnt_n = cnt - 3'd1;
        end else begin
          state_n = SIGN;
        end
      end
      SIGN: begin
        // Negating zero yields zero, so negative zero naturally collapses to 0x000
        res_n    = sign ? (12'd0 - acc) : acc;
        zero_n   = (acc == 12'd0);
        denorm_n = dn_lat;
        done_n   = 1'b1;
        busy_n   = 1'b0;
        state_n  = IDLE;
      end
      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset wins over any in-flight conversion
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      acc    <= 12'd0;
      cnt    <= 3'd0;
      sign   <= 1'b0;
      dn_lat <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      res    <= 12'd0;
      zero   <= 1'b0;
      denorm <= 1'b0;
    end else begin
      state  <= state_n;
      acc    <= acc_n;
      cnt    <= cnt_n;
      sign   <= sign_n;
      dn_lat <= dn_lat_n;
      busy   <= busy_n;
      done   <= done_n;
      res    <= res_n;
      zero   <= zero_n;
      denorm <= denorm_n;
    end
  end

endmodule

// File: tb/tb_fp8_to_fixed.sv
// tb/tb_fp8_to_fixed.sv - scoreboard testbench for fp8_to_fixed
module tb_fp8_to_fixed;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  op;
  logic        busy;
  logic        done;
  logic [11:0] res;
  logic        zero;
  logic        denorm;

  typedef struct {
    logic [11:0] res;
    logic        zero;
    logic        denorm;
    int          due;
    int          blen;
  } item_t;

  item_t sb[$];
  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  int    run = 0;
  int    last_run = 0;
  logic [11:0] held_res = 12'd0;
  logic        held_zero = 1'b0;
  logic        held_dn = 1'b0;

  fp8_to_fixed dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .busy   (busy),
    .done   (done),
    .res    (res),
    .zero   (zero),
    .denorm (denorm)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edge counter used to time done pulses
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Expected result from the FP8 definition: value x 16 = (-1)^S * F * 2^E
  function automatic item_t model(input logic [7:0] o, input int c);
    item_t       r;
    int          mag;
    int          val;
    mag = int'(o[3:0]) * (1 << int'(o[6:4]));
    val = o[7] ? -mag : mag;
    r.res    = val[11:0];
    r.zero   = (mag == 0);
    r.denorm = (o[3:0] != 4'd0) && (o[3] == 1'b0);
    r.due    = c + int'(o[6:4]) + 3;
    r.blen   = int'(o[6:4]) + 2;
    return r;
  endfunction

  // Output monitor: sampled 1ns after each rising edge
  always begin
    @(posedge clk);
    #1;
    if (busy) run++;
    else begin
      last_run = run;
      run = 0;
    end
    if (rst) begin
      sb.delete();
      run = 0;
      held_res = 12'd0;
      held_zero = 1'b0;
      held_dn = 1'b0;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_res", res, 0);
      check("rst_flags", {zero, denorm}, 0);
    end else if (done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 1, 0);
      end else begin
        item_t e;
        e = sb.pop_front();
        check("res", res, e.res);
        check("zero", zero, e.zero);
        check("denorm", denorm, e.denorm);
        check("latency", cyc, e.due);
        check("busy_len", last_run, e.blen);
      end
      held_res = res;
      held_zero = zero;
      held_dn = denorm;
    end else begin
      check("hold", {res, zero, denorm}, {held_res, held_zero, held_dn});
    end
  end

  // Drive one accepted conversion; called right after a falling edge
  task automatic convert(input logic [7:0] o);
    start = 1'b1;
    op = o;
    sb.push_back(model(o, cyc));
    @(negedge clk);
    start = 1'b0;
    op = 8'($urandom);
  endtask

  // Drive a start that the DUT must ignore because it is busy
  task automatic poke(input logic [7:0] o);
    start = 1'b1;
    op = o;
    @(negedge clk);
    start = 1'b0;
    op = 8'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("timeout_idle", 1, 0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!done) check("timeout_done", 1, 0);
  endtask

  // Directed and random stimulus
  initial begin
    rst = 1'b1;
    start = 1'b0;
    op = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_res", res, 0);

    convert(8'h3C);
    wait_idle();
    check("v3c_res", res, 12'h060);

    convert(8'hFF);
    wait_idle();
    check("vff_res", res, 12'h880);

    convert(8'h80);
    wait_idle();
    check("v80_zero", {res, zero}, {12'h000, 1'b1});

    convert(8'h05);
    wait_idle();
    check("v05_res_dn", {res, denorm}, {12'h005, 1'b1});

    // Start during busy is ignored, then back-to-back start in the done cycle
    convert(8'h7F);
    poke(8'h11);
    wait_done();
    check("v7f_res", res, 12'h780);
    convert(8'h11);
    wait_idle();
    check("v11_res", res, 12'h002);

    // Reset mid-shift aborts without a done pulse
    convert(8'h70);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    convert(8'h48);
    wait_idle();
    check("v48_res", res, 12'h080);

    for (int i = 0; i < 16; i++) begin
      convert(8'($urandom));
      wait_idle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
